ad7609_emu: RTL and testbench
=============================

AD7609_EMU -- requirements
Module: ad7609_emu

Interface
REQ-001 Parameter: CONV_CYCLES, default 400, Busy length in Clk cycles for an OS=000 conversion (4 us at 100 MHz).
REQ-002 Port list: one clock; reset is synchronous and active-high.
REQ-003 Clk  in  1  system clock, 100 MHz; every input below is synchronous to Clk.
REQ-004 Rst  in  1  synchronous active-high block reset.
REQ-005 Adc_reset  in  1  emulated ADC RESET pin, active-high.
REQ-006 Convsta, Convstb  in  1 each  conversion-start pins.
REQ-007 Cs_n  in  1  chip select, active-low.
REQ-008 Sclk  in  1  serial clock from controller, at most Clk/4.
REQ-009 Os  in  3  oversampling ratio select.
REQ-010 Pattern_en  in  1  1 = internal test pattern, 0 = Ch_data.
REQ-011 Ch_data  in  144  channel samples, 18 bits per channel; ch1 = [143:126] ... ch8 = [17:0].
REQ-012 Busy  out  1  conversion in progress.
REQ-013 Douta  out  1  serial data for ch1-ch4; 0 when not driven.
REQ-014 Doutb  out  1  serial data for ch5-ch8; 0 when not driven.
REQ-015 Frstdata  out  1  high while the first bit is presented.
REQ-016 Conv_count  out  16  number of completed conversions, wraps at 0xFFFF->0.
REQ-017 Rd_err  out  1  one-cycle pulse on a Sclk falling edge after the 72nd bit.

Function
REQ-018 Clk samples Sclk, Cs_n and cst = Convsta&Convstb into one register each; edges are detected as previous-vs-current.
REQ-019 cst rise with Busy=0 and Adc_reset=0 starts a conversion; Busy=1 from the next Clk edge.
REQ-020 At conversion start, latch Os and the samples:
- Pattern_en=1: channel n value = {n-1 (3 bits), Conv_count[14:0]}.
- Pattern_en=0: Ch_data.
REQ-021 Busy stays high exactly CONV_CYCLES<<k Clk cycles, k = latched Os (0..6); Os=111 is treated as k=0.
REQ-022 cst rise while Busy=1 is ignored; it does not restart or extend the conversion.
REQ-023 On the Busy 1->0 edge, in the same cycle:
- result regs <= latched samples;
- Conv_count increments.
REQ-024 Cs_n fall loads the shift regs from the result regs:
- A = {ch1,ch2,ch3,ch4}, 72 bits; B = {ch5..ch8}, 72 bits;
- from the next Clk edge Douta = A[71], Doutb = B[71], Frstdata = 1.
REQ-025 Each Sclk fall while Cs_n=0 shifts A and B left by 1 on the next Clk edge, so Dout is stable before the next Sclk rise.
REQ-026 Frstdata clears on the first Sclk fall.
REQ-027 A 7-bit bit counter counts Sclk falls. After 72 falls, Douta = Doutb = 0; each further fall pulses Rd_err.
REQ-028 Reading is legal during Busy and returns the previous result. A Busy fall during a read updates the result regs only; the shift in progress is unaffected.
REQ-029 Cs_n rise aborts the read:
- Douta, Doutb, Frstdata = 0 next cycle;
- bit counter = 0;
- the next Cs_n fall restarts at bit 71.
REQ-030 Adc_reset=1, held for any length:
- aborts the conversion; Busy = 0 next cycle;
- result regs = 0; Conv_count unchanged;
- cst edges are ignored while it is high.
REQ-031 Rst=1 has priority over Adc_reset.

Reset
REQ-032 On Rst, at the next Clk edge:
- Busy, Douta, Doutb, Frstdata, Rd_err = 0;
- Conv_count = 0;
- result and shift regs = 0, bit counter = 0;
- edge-detect regs: Cs_n = 1, Sclk = 0, cst = 1.
REQ-033 Rst asserted mid-conversion or mid-read is a full reset; no conversion completes.

Verification
REQ-034 Bench shall cover:
- CONV_CYCLES=400, Os=000, cst rise -> Busy high exactly 400 cycles, Conv_count 0->1.
- Os=010 -> Busy 1600 cycles.
- Os=111 -> Busy 400 cycles.
- Pattern_en=1, two conversions, then Cs_n low and 72 Sclk -> Douta bits 71:54 = 0x00001, Doutb bits 71:54 = 0x20001, Frstdata high for the first bit only.
- Pattern_en=0, Ch_data ch1=0x2AAAA, ch8=0x15555 -> Douta first 18 bits 0x2AAAA, Doutb last 18 bits 0x15555; 73rd Sclk fall -> one Rd_err pulse.
- Read during Busy -> previous result shifted out; new result visible on the next Cs_n fall.
- Second cst rise mid-Busy -> Busy length unchanged.
- Adc_reset pulse mid-conversion -> Busy low next cycle, Conv_count unchanged, next read returns 0.
- Cs_n high after 10 bits, then low again -> stream restarts at bit 71 with Frstdata=1.

Source files
------------

// File: rtl/ad7609_emu.sv
// Behavioural emulation of an AD7609 ADC: conversion timing, result latching and the
// dual-lane serial readout (Douta = ch1..ch4, Doutb = ch5..ch8), MSB first.
module ad7609_emu #(
    parameter int CONV_CYCLES = 400
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Adc_reset,
    input  logic         Convsta,
    input  logic         Convstb,
    input  logic         Cs_n,
    input  logic         Sclk,
    input  logic [2:0]   Os,
    input  logic         Pattern_en,
    input  logic [143:0] Ch_data,
    output logic         Busy,
    output logic         Douta,
    output logic         Doutb,
    output logic         Frstdata,
    output logic [15:0]  Conv_count,
    output logic         Rd_err
);
    // state   | meaning
    // ST_IDLE | no conversion running, waiting for a cst rising edge
    // ST_CONV | conversion running, down-timer counts to terminal count 0
    typedef enum logic {ST_IDLE, ST_CONV} state_t;

    localparam int CW = $clog2(CONV_CYCLES * 64 + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  tmr_q, tmr_d;
    logic [143:0]   smp_q, smp_d;
    logic [143:0]   res_q, res_d;
    logic [15:0]    cnt_q, cnt_d;
    logic [71:0]    sha_q, sha_d, shb_q, shb_d;
    logic [6:0]     bit_q, bit_d;
    logic           rd_q, rd_d;
    logic           frst_q, frst_d;
    logic           rderr_q, rderr_d;
    logic           sclk_q, sclk_d, csn_q, csn_d, cst_q, cst_d;

    logic           cst_cur, cst_rise, cs_fall, cs_rise, sclk_fall;
    logic [2:0]     os_k;
    logic [143:0]   pat;

    always_comb begin
        cst_cur   = Convsta & Convstb;
        cst_rise  = cst_cur & ~cst_q;
        cs_fall   = csn_q & ~Cs_n;
        cs_rise   = ~csn_q & Cs_n;
        sclk_fall = sclk_q & ~Sclk;
        os_k      = (Os == 3'b111) ? 3'd0 : Os;
        pat       = '0;
        for (int n = 0; n < 8; n++) begin
            pat[143 - 18*n -: 18] = {3'(n), cnt_q[14:0]};
        end

        state_d = state_q;
        tmr_d   = tmr_q;
        smp_d   = smp_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        bit_d   = bit_q;
        rd_d    = rd_q;
        frst_d  = frst_q;
        rderr_d = 1'b0;
        sclk_d  = Sclk;
        csn_d   = Cs_n;
        cst_d   = cst_cur;

        case (state_q)
            ST_IDLE: begin
                if (cst_rise && !Adc_reset) begin
                    state_d = ST_CONV;
                    tmr_d   = (CW'(CONV_CYCLES) << os_k) - CW'(1);
                    smp_d   = Pattern_en ? pat : Ch_data;
                end
            end
            ST_CONV: begin
                if (tmr_q == '0) begin
                    state_d = ST_IDLE;
                    res_d   = smp_q;
                    cnt_d   = cnt_q + 16'd1;
                end else begin
                    tmr_d = tmr_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // ADC reset wins over a completion landing in the same cycle
        if (Adc_reset) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
            res_d   = '0;
            cnt_d   = cnt_q;
        end

        if (cs_rise) begin
            rd_d   = 1'b0;
            bit_d  = '0;
            frst_d = 1'b0;
        end else if (cs_fall) begin
            rd_d   = 1'b1;
            sha_d  = res_q[143:72];
            shb_d  = res_q[71:0];
            bit_d  = '0;
            frst_d = 1'b1;
        end else if (sclk_fall && rd_q && !Cs_n) begin
            if (bit_q < 7'd72) begin
                sha_d  = {sha_q[70:0], 1'b0};
                shb_d  = {shb_q[70:0], 1'b0};
                bit_d  = bit_q + 7'd1;
                frst_d = 1'b0;
            end else begin
                rderr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            tmr_q   <= '0;
            smp_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sha_q   <= '0;
            shb_q   <= '0;
            bit_q   <= '0;
            rd_q    <= 1'b0;
            frst_q  <= 1'b0;
            rderr_q <= 1'b0;
            sclk_q  <= 1'b0;
            csn_q   <= 1'b1;
            cst_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            smp_q   <= smp_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            frst_q  <= frst_d;
            rderr_q <= rderr_d;
            sclk_q  <= sclk_d;
            csn_q   <= csn_d;
            cst_q   <= cst_d;
        end
    end

    assign Busy       = (state_q == ST_CONV);
    assign Douta      = rd_q && (bit_q < 7'd72) && sha_q[71];
    assign Doutb      = rd_q && (bit_q < 7'd72) && shb_q[71];
    assign Frstdata   = frst_q;
    assign Conv_count = cnt_q;
    assign Rd_err     = rderr_q;
endmodule

// File: tb/tb_ad7609_emu.sv
// Randomized bench for ad7609_emu with a channel-level reference model
// (conversion count, eight 18-bit result words) kept independently of the RTL.
module tb_ad7609_emu;
    logic         clk = 1'b0;
    logic         Rst, Adc_reset, Convsta, Convstb, Cs_n, Sclk, Pattern_en;
    logic [2:0]   Os;
    logic [143:0] Ch_data;
    logic         Busy, Douta, Doutb, Frstdata, Rd_err;
    logic [15:0]  Conv_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] m_count;
    logic [17:0] m_res [8];

    ad7609_emu #(.CONV_CYCLES(400)) dut (
        .Clk(clk), .Rst(Rst), .Adc_reset(Adc_reset), .Convsta(Convsta), .Convstb(Convstb),
        .Cs_n(Cs_n), .Sclk(Sclk), .Os(Os), .Pattern_en(Pattern_en), .Ch_data(Ch_data),
        .Busy(Busy), .Douta(Douta), .Doutb(Doutb), .Frstdata(Frstdata),
        .Conv_count(Conv_count), .Rd_err(Rd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] exp_a();
        return {m_res[0], m_res[1], m_res[2], m_res[3]};
    endfunction

    function automatic logic [71:0] exp_b();
        return {m_res[4], m_res[5], m_res[6], m_res[7]};
    endfunction

    function automatic int busy_len(input logic [2:0] os);
        return (os == 3'b111) ? 400 : 400 * (1 << os);
    endfunction

    task automatic rand_data();
        for (int n = 0; n < 8; n++) Ch_data[143 - 18*n -: 18] = 18'($urandom_range(0, 262143));
    endtask

    task automatic do_reset();
        @(negedge clk);
        Rst = 1'b1;
        repeat (3) @(negedge clk);
        Rst = 1'b0;
        m_count = '0;
        for (int n = 0; n < 8; n++) m_res[n] = '0;
        @(negedge clk);
    endtask

    // Runs one conversion to completion and returns the measured Busy length.
    task automatic do_conv(input logic [2:0] os, input bit retrig, output int len);
        logic [17:0] lat [8];
        int guard;
        @(negedge clk);
        Os = os;
        for (int n = 0; n < 8; n++)
            lat[n] = Pattern_en ? {3'(n), m_count[14:0]} : Ch_data[143 - 18*n -: 18];
        Convsta = 1'b1;
        Convstb = 1'b1;
        len = 0;
        guard = 0;
        @(negedge clk);
        while (Busy === 1'b1 && guard < 30000) begin
            len++;
            if (len == 2) begin Convsta = 1'b0; Convstb = 1'b0; end
            if (retrig && len == 100) begin Convsta = 1'b1; Convstb = 1'b1; end
            if (retrig && len == 150) begin Convsta = 1'b0; Convstb = 1'b0; end
            @(negedge clk);
            guard++;
        end
        Convsta = 1'b0;
        Convstb = 1'b0;
        for (int n = 0; n < 8; n++) m_res[n] = lat[n];
        m_count = m_count + 16'd1;
        @(negedge clk);
    endtask

    // Drops Cs_n and collects nbits bits, issuing one Sclk pulse per bit; leaves Cs_n low.
    task automatic read_frame(input int nbits, output logic [71:0] a, output logic [71:0] b,
                              output int frst_bad);
        a = '0;
        b = '0;
        frst_bad = 0;
        @(negedge clk);
        Cs_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            a = {a[70:0], Douta};
            b = {b[70:0], Doutb};
            if (Frstdata !== (i == 0)) frst_bad++;
            Sclk = 1'b1;
            repeat (2) @(negedge clk);
            Sclk = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic end_read();
        @(negedge clk);
        Cs_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({Busy, Douta, Doutb, Frstdata, Rd_err} !== 5'b0)
            $display("FAIL reset_outputs got=%b want=00000", {Busy, Douta, Doutb, Frstdata, Rd_err});
        else n_pass++;
        n_checks++;
        if (Conv_count !== 16'd0) $display("FAIL reset_count got=%0d want=0", Conv_count);
        else n_pass++;
    endtask

    task automatic test_busy_length();
        int len;
        logic [2:0] os_list [4];
        os_list[0] = 3'b000;
        os_list[1] = 3'b010;
        os_list[2] = 3'b111;
        os_list[3] = 3'($urandom_range(1, 3));
        Pattern_en = 1'b0;
        // single conversion-start pin must not start anything
        @(negedge clk);
        Convsta = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0) $display("FAIL single_pin_start got=%b want=0", Busy);
        else n_pass++;
        Convsta = 1'b0;
        for (int t = 0; t < 4; t++) begin
            rand_data();
            do_conv(os_list[t], 1'b0, len);
            n_checks++;
            if (len !== busy_len(os_list[t]))
                $display("FAIL busy_len os=%0d got=%0d want=%0d", os_list[t], len, busy_len(os_list[t]));
            else n_pass++;
            n_checks++;
            if (Conv_count !== m_count) $display("FAIL conv_count got=%0d want=%0d", Conv_count, m_count);
            else n_pass++;
        end
    endtask

    task automatic test_pattern();
        int len, fb;
        logic [71:0] a, b;
        do_reset();
        Pattern_en = 1'b1;
        do_conv(3'b000, 1'b0, len);
        do_conv(3'b000, 1'b0, len);
        read_frame(72, a, b, fb);
        end_read();
        n_checks++;
        if (a[71:54] !== 18'h00001 || b[71:54] !== 18'h20001)
            $display("FAIL pattern_first got=%h/%h want=00001/20001", a[71:54], b[71:54]);
        else n_pass++;
        n_checks++;
        if (a !== exp_a() || b !== exp_b())
            $display("FAIL pattern_frame got=%h/%h want=%h/%h", a, b, exp_a(), exp_b());
        else n_pass++;
        n_checks++;
        if (fb !== 0) $display("FAIL pattern_frstdata bad_bits got=%0d want=0", fb);
        else n_pass++;
    endtask

    task automatic test_data_and_rd_err();
        int len, fb, pulses;
        logic [71:0] a, b;
        Pattern_en = 1'b0;
        for (int r = 0; r < 3; r++) begin
            rand_data();
            if (r == 0) begin
                Ch_data[143:126] = 18'h2AAAA;
                Ch_data[17:0]    = 18'h15555;
            end
            do_conv(3'($urandom_range(0, 1)), 1'b0, len);
            read_frame(72, a, b, fb);
            n_checks++;
            if (a !== exp_a() || b !== exp_b() || fb !== 0)
                $display("FAIL data_frame r=%0d got=%h/%h frst_bad=%0d want=%h/%h", r, a, b, fb, exp_a(), exp_b());
            else n_pass++;
            if (r == 0) begin
                n_checks++;
                if (a[71:54] !== 18'h2AAAA || b[17:0] !== 18'h15555)
                    $display("FAIL data_edges got=%h/%h want=2aaaa/15555", a[71:54], b[17:0]);
                else n_pass++;
                n_checks++;
                if (Douta !== 1'b0 || Doutb !== 1'b0)
                    $display("FAIL dout_after_72 got=%b%b want=00", Douta, Doutb);
                else n_pass++;
                pulses = 0;
                Sclk = 1'b1;
                repeat (2) begin @(negedge clk); pulses += int'(Rd_err); end
                Sclk = 1'b0;
                repeat (3) begin @(negedge clk); pulses += int'(Rd_err); end
                n_checks++;
                if (pulses !== 1) $display("FAIL rd_err_pulses got=%0d want=1", pulses);
                else n_pass++;
            end
            end_read();
        end
    endtask

    task automatic test_read_during_busy();
        int len, fb;
        logic [71:0] a, b, pa, pb;
        Pattern_en = 1'b0;
        pa = exp_a();
        pb = exp_b();
        rand_data();
        fork
            do_conv(3'b000, 1'b0, len);
            begin
                repeat (200) @(negedge clk);
                read_frame(72, a, b, fb);
            end
        join
        end_read();
        n_checks++;
        if (a !== pa || b !== pb || fb !== 0)
            $display("FAIL read_in_busy got=%h/%h want=%h/%h", a, b, pa, pb);
        else n_pass++;
        read_frame(72, a, b, fb);
        end_read();
        n_checks++;
        if (a !== exp_a() || b !== exp_b())
            $display("FAIL read_after_busy got=%h/%h want=%h/%h", a, b, exp_a(), exp_b());
        else n_pass++;
    endtask

    task automatic test_retrigger();
        int len;
        rand_data();
        do_conv(3'b000, 1'b1, len);
        n_checks++;
        if (len !== 400) $display("FAIL retrigger_len got=%0d want=400", len);
        else n_pass++;
        n_checks++;
        if (Conv_count !== m_count) $display("FAIL retrigger_count got=%0d want=%0d", Conv_count, m_count);
        else n_pass++;
    endtask

    task automatic test_adc_reset();
        int fb;
        logic [71:0] a, b;
        rand_data();
        @(negedge clk);
        Os = 3'b000;
        Convsta = 1'b1;
        Convstb = 1'b1;
        repeat (50) @(negedge clk);
        Convsta = 1'b0;
        Convstb = 1'b0;
        repeat (50) @(negedge clk);
        Adc_reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0) $display("FAIL adc_reset_busy got=%b want=0", Busy);
        else n_pass++;
        Convsta = 1'b1;
        Convstb = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (Busy !== 1'b0) $display("FAIL adc_reset_cst_ignored got=%b want=0", Busy);
        else n_pass++;
        Adc_reset = 1'b0;
        repeat (3) @(negedge clk);
        Convsta = 1'b0;
        Convstb = 1'b0;
        for (int n = 0; n < 8; n++) m_res[n] = '0;
        n_checks++;
        if (Busy !== 1'b0 || Conv_count !== m_count)
            $display("FAIL adc_reset_state got=busy %b count %0d want=busy 0 count %0d", Busy, Conv_count, m_count);
        else n_pass++;
        read_frame(72, a, b, fb);
        end_read();
        n_checks++;
        if (a !== 72'd0 || b !== 72'd0) $display("FAIL adc_reset_read got=%h/%h want=0/0", a, b);
        else n_pass++;
    endtask

    task automatic test_abort();
        int len, fb;
        logic [71:0] a, b, ea;
        rand_data();
        do_conv(3'b000, 1'b0, len);
        ea = exp_a();
        read_frame(10, a, b, fb);
        n_checks++;
        if (a[9:0] !== ea[71:62]) $display("FAIL abort_partial got=%h want=%h", a[9:0], ea[71:62]);
        else n_pass++;
        @(negedge clk);
        Cs_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({Douta, Doutb, Frstdata} !== 3'b000)
            $display("FAIL abort_outputs got=%b want=000", {Douta, Doutb, Frstdata});
        else n_pass++;
        read_frame(72, a, b, fb);
        end_read();
        n_checks++;
        if (a !== exp_a() || b !== exp_b() || fb !== 0)
            $display("FAIL abort_restart got=%h/%h frst_bad=%0d want=%h/%h", a, b, fb, exp_a(), exp_b());
        else n_pass++;
    endtask

    task automatic test_rst_mid_conv();
        @(negedge clk);
        Os = 3'b000;
        Convsta = 1'b1;
        Convstb = 1'b1;
        repeat (50) @(negedge clk);
        Convsta = 1'b0;
        Convstb = 1'b0;
        do_reset();
        n_checks++;
        if (Busy !== 1'b0 || Conv_count !== 16'd0)
            $display("FAIL rst_mid got=busy %b count %0d want=busy 0 count 0", Busy, Conv_count);
        else n_pass++;
        repeat (500) @(negedge clk);
        n_checks++;
        if (Conv_count !== m_count) $display("FAIL rst_no_complete got=%0d want=%0d", Conv_count, m_count);
        else n_pass++;
    endtask

    initial begin
        Rst = 1'b0; Adc_reset = 1'b0; Convsta = 1'b0; Convstb = 1'b0;
        Cs_n = 1'b1; Sclk = 1'b0; Os = 3'b000; Pattern_en = 1'b0; Ch_data = '0;
        m_count = '0;
        for (int n = 0; n < 8; n++) m_res[n] = '0;
        test_reset();
        test_busy_length();
        test_pattern();
        test_data_and_rd_err();
        test_read_during_busy();
        test_retrigger();
        test_adc_reset();
        test_abort();
        test_rst_mid_conv();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
